// File: rtl/branch_resolve_queue.sv
// rtl/branch_resolve_queue.sv - in-order branch prediction tracker feeding the BHT write port
// Circular FIFO of {idx, taken}; oldest-first resolution drives a registered BHT update and flush pulse.
module branch_resolve_queue #(
  parameter int width = 10,
  parameter int depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pred_valid,
  input  logic [width-1:0]           pred_idx,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  output logic                       res_ready,
  output logic                       bht_load,
  output logic [width-1:0]           bht_w_idx,
  output logic                       bht_taken,
  output logic                       bht_correct,
  output logic                       mispredict,
  output logic [$clog2(depth):0]     count
);

  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);

  logic [width-1:0] r_mem_idx [depth];
  logic             r_mem_tkn [depth];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_bht_load;
  logic [width-1:0] r_bht_w_idx;
  logic             r_bht_taken;
  logic             r_bht_correct;
  logic             r_mispredict;

  logic             w_push;
  logic             w_pop;
  logic             w_flush;
  logic [width-1:0] w_head_idx;
  logic             w_head_tkn;
  logic [PW-1:0]    w_head_nxt;

  assign w_head_idx = r_mem_idx[r_head];
  assign w_head_tkn = r_mem_tkn[r_head];
  assign w_head_nxt = r_head + PW'(1);

  // The flush cycle blocks fetch so wrong-path pushes cannot slip in behind the redirect.
  assign pred_ready = (r_count < DEPTH_C) && !r_mispredict;
  assign res_ready  = (r_count != '0);
  assign w_push     = pred_valid && pred_ready;
  assign w_pop      = res_valid && res_ready;
  assign w_flush    = w_pop && (w_head_tkn != res_taken);

  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_mem_idx[r_tail] <= pred_idx;
      r_mem_tkn[r_tail] <= pred_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      // Popping the head and discarding everything younger leaves an empty queue at head+1.
      r_head  <= w_head_nxt;
      r_tail  <= w_head_nxt;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= w_head_nxt;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bht_load    <= 1'b0;
      r_bht_w_idx   <= '0;
      r_bht_taken   <= 1'b0;
      r_bht_correct <= 1'b0;
      r_mispredict  <= 1'b0;
    end else begin
      r_bht_load   <= w_pop;
      r_mispredict <= w_flush;
      if (w_pop) begin
        r_bht_w_idx   <= w_head_idx;
        r_bht_taken   <= w_head_tkn;
        r_bht_correct <= (w_head_tkn == res_taken);
      end
    end
  end

  assign bht_load    = r_bht_load;
  assign bht_w_idx   = r_bht_w_idx;
  assign bht_taken   = r_bht_taken;
  assign bht_correct = r_bht_correct;
  assign mispredict  = r_mispredict;
  assign count       = r_count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb/tb_branch_resolve_queue.sv - directed self-checking bench for branch_resolve_queue
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_branch_resolve_queue;

  logic       clk;
  logic       rst;
  logic       pred_valid;
  logic [9:0] pred_idx;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       res_ready;
  logic       bht_load;
  logic [9:0] bht_w_idx;
  logic       bht_taken;
  logic       bht_correct;
  logic       mispredict;
  logic [2:0] count;

  int n_checks;
  int n_errors;

  branch_resolve_queue #(.width(10), .depth(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .pred_valid (pred_valid),
    .pred_idx   (pred_idx),
    .pred_taken (pred_taken),
    .pred_ready (pred_ready),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .res_ready  (res_ready),
    .bht_load   (bht_load),
    .bht_w_idx  (bht_w_idx),
    .bht_taken  (bht_taken),
    .bht_correct(bht_correct),
    .mispredict (mispredict),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [9:0] idx, input logic tkn);
    pred_valid = 1'b1; pred_idx = idx; pred_taken = tkn;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic tkn);
    res_valid = 1'b1; res_taken = tkn;
    tick();
    res_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst = 1'b1; pred_valid = 1'b0; pred_idx = '0; pred_taken = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: reset state, single correct resolution
    check("rst_count", count, 0);
    check("rst_pred_ready", pred_ready, 1);
    check("rst_res_ready", res_ready, 0);
    check("rst_load", bht_load, 0);
    check("rst_mis", mispredict, 0);
    check("rst_widx", bht_w_idx, 0);
    push(10'h005, 1'b1);
    check("t1_count1", count, 1);
    check("t1_res_ready", res_ready, 1);
    resolve(1'b1);
    check("t1_load", bht_load, 1);
    check("t1_widx", bht_w_idx, 10'h005);
    check("t1_taken", bht_taken, 1);
    check("t1_correct", bht_correct, 1);
    check("t1_mis", mispredict, 0);
    check("t1_count0", count, 0);
    tick();
    check("t1_load_drop", bht_load, 0);
    check("t1_widx_hold", bht_w_idx, 10'h005);

    // 2: fill to depth, overflow push ignored, pop does not enable a push when full
    for (int i = 0; i < 4; i++) push(10'h100 + 10'(i), 1'b1);
    check("t2_full_count", count, 4);
    check("t2_full_ready", pred_ready, 0);
    push(10'h1ff, 1'b1);
    check("t2_ovf_count", count, 4);
    pred_valid = 1'b1; pred_idx = 10'h1fe; pred_taken = 1'b1;
    resolve(1'b1);
    pred_valid = 1'b0;
    check("t2_pop_count", count, 3);
    check("t2_pop_ready", pred_ready, 1);
    check("t2_pop_widx", bht_w_idx, 10'h100);
    for (int i = 1; i < 4; i++) begin
      resolve(1'b1);
      check("t2_drain_widx", bht_w_idx, 10'h100 + 10'(i));
    end
    check("t2_drain_count", count, 0);

    // 3: mispredict flushes younger entries
    push(10'h010, 1'b0);
    push(10'h011, 1'b1);
    push(10'h012, 1'b1);
    check("t3_count3", count, 3);
    resolve(1'b1);
    check("t3_load", bht_load, 1);
    check("t3_widx", bht_w_idx, 10'h010);
    check("t3_taken", bht_taken, 0);
    check("t3_correct", bht_correct, 0);
    check("t3_mis", mispredict, 1);
    check("t3_count", count, 0);
    check("t3_res_ready", res_ready, 0);
    check("t3_pred_ready", pred_ready, 0);
    tick();
    check("t3_mis_drop", mispredict, 0);
    check("t3_pred_ready_back", pred_ready, 1);
    check("t3_load_drop", bht_load, 0);

    // 4: simultaneous push/pop and wrap ordering
    push(10'h020, 1'b1);
    push(10'h021, 1'b1);
    pred_valid = 1'b1; pred_idx = 10'h022; pred_taken = 1'b1;
    resolve(1'b1);
    pred_valid = 1'b0;
    check("t4_sim_count", count, 2);
    check("t4_sim_widx", bht_w_idx, 10'h020);
    for (int i = 0; i < 10; i++) begin
      pred_valid = 1'b1; pred_idx = 10'h030 + 10'(i); pred_taken = 1'b1;
      resolve(1'b1);
      pred_valid = 1'b0;
      check("t4_wrap_load", bht_load, 1);
      check("t4_wrap_widx", bht_w_idx, (i == 0) ? 10'h021 : (i == 1) ? 10'h022 : 10'h030 + 10'(i - 2));
      check("t4_wrap_count", count, 2);
    end
    resolve(1'b1);
    check("t4_tail_widx0", bht_w_idx, 10'h038);
    resolve(1'b1);
    check("t4_tail_widx1", bht_w_idx, 10'h039);
    check("t4_empty", count, 0);

    // 5: resolve while empty; mispredict drops a same-cycle push
    resolve(1'b1);
    check("t5_empty_load", bht_load, 0);
    check("t5_empty_count", count, 0);
    push(10'h040, 1'b1);
    pred_valid = 1'b1; pred_idx = 10'h041; pred_taken = 1'b1;
    resolve(1'b0);
    pred_valid = 1'b0;
    check("t5_mis", mispredict, 1);
    check("t5_widx", bht_w_idx, 10'h040);
    check("t5_correct", bht_correct, 0);
    check("t5_count", count, 0);
    tick();
    check("t5_count_after", count, 0);
    check("t5_res_ready", res_ready, 0);

    // 6: asynchronous reset right after a pop edge
    push(10'h050, 1'b1);
    push(10'h051, 1'b1);
    push(10'h052, 1'b1);
    check("t6_count3", count, 3);
    res_valid = 1'b1; res_taken = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    res_valid = 1'b0;
    check("t6_rst_load", bht_load, 0);
    check("t6_rst_widx", bht_w_idx, 0);
    check("t6_rst_taken", bht_taken, 0);
    check("t6_rst_correct", bht_correct, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_pred_ready", pred_ready, 1);
    check("t6_rst_res_ready", res_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_post_load", bht_load, 0);
    check("t6_post_pred_ready", pred_ready, 1);
    check("t6_post_count", count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
